hu_rr_arbiter: RTL and testbench

- Registered round-robin arbiter. Takes `width` request lines and produces a one-hot grant vector that drives a one-hot selector's `sel` input directly.
- It sits on the initiator side of a shared-resource mux: it decides which source the selector passes through, and it holds that choice until the downstream consumer accepts the transfer.
- Fairness is rotating priority: the most recently served requester becomes lowest priority.

---
 rtl/hu_rr_arbiter_pkg.sv | 12 +
 rtl/hu_rr_pick.sv | 40 ++++
 rtl/hu_rr_arbiter.sv | 80 ++++++++
 tb/tb_hu_rr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hu_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter family.
package hu_rr_arbiter_pkg;

    // Largest requester count this arbiter family is meant to serve.
    localparam int MaxWidth = 32;

    // Width of a binary index into a vector of n entries, never below one bit.
    function automatic int clogMin1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hu_rr_pick.sv
// Combinational rotating-priority picker.
// Finds the first set request at or after ptr_i, wrapping around.
// It returns that request as a one-hot vector, a binary index and an any-flag.
module hu_rr_pick
    import hu_rr_arbiter_pkg::*;
#(
    parameter int width = 4,
    parameter int idx_w = clogMin1(width)
) (
    input  logic [width-1:0] req_i,
    input  logic [idx_w-1:0] ptr_i,
    output logic [width-1:0] onehot_o,
    output logic [idx_w-1:0] idx_o,
    output logic             any_o
);

    logic [2*width-1:0] doubled;
    logic               found;
    int                 hitPos;
    int                 hitIdx;

    // Duplicate the request vector and ignore entries below ptr_i.
    // The lowest surviving bit is then the winner in wrapped priority order.
    always_comb begin
        doubled = {req_i, req_i};
        found   = 1'b0;
        hitPos  = 0;
        for (int i = 2*width-1; i >= 0; i--) begin
            if (doubled[i] && (i >= int'(ptr_i))) begin
                hitPos = i;
                found  = 1'b1;
            end
        end
        hitIdx   = (hitPos >= width) ? (hitPos - width) : hitPos;
        idx_o    = idx_w'(hitIdx);
        any_o    = found;
        onehot_o = found ? (width'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/hu_rr_arbiter.sv
// Registered round-robin arbiter.
// The grant is one-hot and is held until the downstream consumer accepts it.
// The source just served drops to lowest priority for the next pick.
module hu_rr_arbiter
    import hu_rr_arbiter_pkg::*;
#(
    parameter int width = 4,
    // Derived from width; leave at its default.
    parameter int idx_w = clogMin1(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] req,
    input  logic             ready,
    output logic [width-1:0] grant,
    output logic [idx_w-1:0] grant_idx,
    output logic             valid,
    output logic             xfer
);

    logic [width-1:0] grant_q, grant_d;
    logic [idx_w-1:0] idx_q, idx_d;
    logic [idx_w-1:0] ptr_q, ptr_d;
    logic [idx_w-1:0] advPtr;
    logic [idx_w-1:0] pickPtr;
    logic [width-1:0] pickOneHot;
    logic [idx_w-1:0] pickIdx;
    logic             pickAny;
    logic             busy;

    // Compute the priority pointer that follows the currently granted source, wrapping at width.
    always_comb begin
        busy    = |grant_q;
        advPtr  = (idx_q == idx_w'(width-1)) ? '0 : (idx_q + idx_w'(1));
        pickPtr = busy ? advPtr : ptr_q;
    end

    hu_rr_pick #(
        .width (width),
        .idx_w (idx_w)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (pickPtr),
        .onehot_o (pickOneHot),
        .idx_o    (pickIdx),
        .any_o    (pickAny)
    );

    // Hold the grant while busy and not accepted.
    // When idle or on a completed transfer, take a fresh pick in the same cycle.
    always_comb begin
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (!busy || ready) begin
            grant_d = pickOneHot;
            idx_d   = pickAny ? pickIdx : '0;
            ptr_d   = busy ? advPtr : ptr_q;
        end
    end

    // Register grant, encoded index and priority pointer; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign valid     = busy;
    assign xfer      = busy & ready;

endmodule

// File: tb/tb_hu_rr_arbiter.sv
// Self-checking bench for hu_rr_arbiter: directed scenarios plus a randomized run
// compared against a rotating-priority reference model.
module tb_hu_rr_arbiter;

    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req;
    logic          ready;
    logic [W-1:0]  grant;
    logic [IW-1:0] grantIdx;
    logic          valid;
    logic          xfer;

    int checks = 0;
    int errors = 0;

    // Reference model state: granted source (-1 when idle), priority start, last served source.
    int mGrant  = -1;
    int mPtr    = 0;
    int mServed = -1;
    int mWait [W];

    hu_rr_arbiter #(.width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .grant     (grant),
        .grant_idx (grantIdx),
        .valid     (valid),
        .xfer      (xfer)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // First requesting source when scanning upward from p with wrap-around, or -1.
    function automatic int modelPick(input logic [W-1:0] r, input int p);
        for (int k = 0; k < W; k++) begin
            if (r[(p + k) % W]) return (p + k) % W;
        end
        return -1;
    endfunction

    // Behavioural reference: advance the model on every rising edge from the sampled inputs.
    // It also counts, for each waiting source, how many other transfers went by.
    always @(posedge clk) begin
        if (rst) begin
            mGrant  = -1;
            mPtr    = 0;
            mServed = -1;
            for (int i = 0; i < W; i++) mWait[i] = 0;
        end else begin
            mServed = -1;
            if (mGrant >= 0 && ready) begin
                mServed = mGrant;
                for (int i = 0; i < W; i++) begin
                    if (i == mGrant)  mWait[i] = 0;
                    else if (req[i])  mWait[i] = mWait[i] + 1;
                    else              mWait[i] = 0;
                end
                mPtr   = (mGrant + 1) % W;
                mGrant = modelPick(req, mPtr);
            end else begin
                for (int i = 0; i < W; i++) if (!req[i]) mWait[i] = 0;
                if (mGrant < 0) mGrant = modelPick(req, mPtr);
            end
        end
    end

    task automatic doReset();
        rst   = 1'b1;
        req   = '0;
        ready = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1; req = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_idle_grant cyc %0d: got %b expected 0000", k, grant); end
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_valid cyc %0d: got %b expected 0", k, valid); end
            checks++; if (grantIdx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idle_idx cyc %0d: got %0d expected 0", k, grantIdx); end
        end
        req = 4'b0010;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL reset_pre_grant: got %b expected 0010", grant); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_midgrant: got %b expected 0000", grant); end
        checks++; if (xfer !== 1'b0) begin errors++; $display("[TB] FAIL reset_midgrant_xfer: got %b expected 0", xfer); end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_hold();
        $display("[TB] test_hold");
        doReset();
        req = 4'b1010; ready = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL hold_first_grant: got %b expected 0010", grant); end
        checks++; if (grantIdx !== 2'd1) begin errors++; $display("[TB] FAIL hold_first_idx: got %0d expected 1", grantIdx); end
        req = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL hold_grant cyc %0d: got %b expected 0010", k, grant); end
            checks++; if (xfer !== 1'b0) begin errors++; $display("[TB] FAIL hold_xfer cyc %0d: got %b expected 0", k, xfer); end
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] expG;
        $display("[TB] test_rotation");
        doReset();
        req = 4'b1111; ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expG = '0;
            expG[k % W] = 1'b1;
            checks++; if (grant !== expG) begin errors++; $display("[TB] FAIL rotation_grant step %0d: got %b expected %b", k, grant, expG); end
            checks++; if (grantIdx !== IW'(k % W)) begin errors++; $display("[TB] FAIL rotation_idx step %0d: got %0d expected %0d", k, grantIdx, k % W); end
            checks++; if (xfer !== 1'b1) begin errors++; $display("[TB] FAIL rotation_xfer step %0d: got %b expected 1", k, xfer); end
        end
        ready = 1'b0;
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        doReset();
        req = 4'b0100; ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant cyc %0d: got %b expected 0100", k, grant); end
            checks++; if (grantIdx !== 2'd2) begin errors++; $display("[TB] FAIL single_idx cyc %0d: got %0d expected 2", k, grantIdx); end
        end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        doReset();
        req = 4'b1001; ready = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_first: got %b expected 0001", grant); end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_after_ptr1: got %b expected 1000", grant); end
        checks++; if (grantIdx !== 2'd3) begin errors++; $display("[TB] FAIL b2b_idx3: got %0d expected 3", grantIdx); end
        req = 4'b0001;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_wrap: got %b expected 0001", grant); end
        req = 4'b1001;
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_ptr_after_wrap: got %b expected 1000", grant); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_to_idle_valid: got %b expected 0", valid); end
        checks++; if (grantIdx !== 2'd0) begin errors++; $display("[TB] FAIL b2b_to_idle_idx: got %0d expected 0", grantIdx); end
        ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] expG;
        logic [W-1:0] nextReq;
        int expIdx;
        int maxWait;
        $display("[TB] test_random");
        doReset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            expG = '0;
            if (mGrant >= 0) expG[mGrant] = 1'b1;
            expIdx = (mGrant < 0) ? 0 : mGrant;
            maxWait = 0;
            for (int i = 0; i < W; i++) if (mWait[i] > maxWait) maxWait = mWait[i];
            checks++; if (grant !== expG) begin errors++; $display("[TB] FAIL rand_grant cyc %0d: got %b expected %b", c, grant, expG); end
            checks++; if (grantIdx !== IW'(expIdx)) begin errors++; $display("[TB] FAIL rand_idx cyc %0d: got %0d expected %0d", c, grantIdx, expIdx); end
            checks++; if (valid !== (mGrant >= 0)) begin errors++; $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", c, valid, (mGrant >= 0)); end
            checks++; if (xfer !== ((mGrant >= 0) && ready)) begin errors++; $display("[TB] FAIL rand_xfer cyc %0d: got %b expected %b", c, xfer, ((mGrant >= 0) && ready)); end
            checks++; if ($onehot0(grant) !== 1'b1) begin errors++; $display("[TB] FAIL rand_onehot0 cyc %0d: got %b expected at most one bit", c, grant); end
            checks++; if ((grant & ~req) !== '0) begin errors++; $display("[TB] FAIL rand_protocol cyc %0d: grant %b req %b expected grant within req", c, grant, req); end
            checks++; if (maxWait > W - 1) begin errors++; $display("[TB] FAIL rand_starvation cyc %0d: got %0d waits expected <= %0d", c, maxWait, W - 1); end
            nextReq = req;
            for (int i = 0; i < W; i++) begin
                if (mGrant == i)                 nextReq[i] = 1'b1;
                else if (req[i] && mServed == i) nextReq[i] = ($urandom_range(0, 1) == 0);
                else if (req[i])                 nextReq[i] = 1'b1;
                else                             nextReq[i] = ($urandom_range(0, 3) == 0);
            end
            req   = nextReq;
            ready = ($urandom_range(0, 1) == 1);
        end
        req = '0; ready = 1'b0;
    endtask

    // Run every scenario in order, then report the totals.
    initial begin
        rst = 1'b1; req = '0; ready = 1'b0;
        test_reset();
        test_hold();
        test_rotation();
        test_single();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
